// File: rtl/bfly_pair_feeder_pkg.sv
// Shared definitions for the butterfly pair feeder: default sample width and
// block length, the fill/drain state type, the sample type, and the width
// helper for the pair-index port.
package bfly_pkg;

    localparam int W_DEF = 15;
    localparam int N_DEF = 8;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } bfly_state_e;

    typedef logic signed [W_DEF-1:0] sample_t;

    // Width of the pair index k in 0..N/2-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n / 2) : 1;
    endfunction

endpackage

// File: rtl/bfly_pair_feeder_bank.sv
// N x W sample register file: one synchronous write port and two
// combinational read ports returning a mirrored pair (k, N-1-k).
// Contents are never reset; the feeder's counters and flags decide what is valid.
module bfly_bank
    import bfly_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = N_DEF,
    localparam int AW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_waddr,
    input  logic signed [W-1:0]  i_wdata,
    input  logic [AW-1:0]        i_rk,
    output logic signed [W-1:0]  o_rd_a,
    output logic signed [W-1:0]  o_rd_b
);

    localparam logic [AW-1:0] TOP_ADDR = AW'(N - 1);

    logic signed [W-1:0] r_mem [N];
    logic [AW-1:0]       w_mirror;

    // Store each accepted sample at its arrival position.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign w_mirror = TOP_ADDR - i_rk;
    assign o_rd_a   = r_mem[i_rk];
    assign o_rd_b   = r_mem[w_mirror];

endmodule

// File: rtl/bfly_pair_feeder.sv
// Input-side stage of the transform datapath: gathers N serial samples into a
// block and presents mirrored pairs (x[k], x[N-1-k]) to the butterfly.
// Build option: BFLY_FEEDER_PINGPONG_EN selects a two-bank ping-pong buffer
// that accepts one sample per cycle continuously; without it a single bank
// alternates between FILL and DRAIN.
// Handshake: a beat happens on a side whenever valid and ready are both high
// at a rising edge; a presented pair stays constant until it is taken.
// dbg_state: single bank {0, state}; ping-pong {full[1], full[0]}.
module bfly_pair_feeder
    import bfly_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = N_DEF,
    localparam int KW = idx_width(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [W-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [W-1:0]  out_a,
    output logic signed [W-1:0]  out_b,
    output logic [KW-1:0]        out_idx,
    output logic                 out_last,
    output logic [1:0]           dbg_state
);

    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST_WR = AW'(N - 1);
    localparam logic [AW-1:0] LAST_RD = AW'(N / 2 - 1);

    logic                r_in_ready;
    logic                r_out_valid;
    logic signed [W-1:0] r_out_a;
    logic signed [W-1:0] r_out_b;
    logic [KW-1:0]       r_out_idx;
    logic                r_out_last;
    logic [AW-1:0]       r_wr_cnt;
    logic [AW-1:0]       r_rd_cnt;

    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_fill_done;
    logic [AW-1:0]       w_nk;
    logic                w_load;
    logic                w_bypass;
    logic                w_other_full;
    logic                w_wr_bank;
    logic                w_rd_bank;
    logic signed [W-1:0] w_rd_a;
    logic signed [W-1:0] w_rd_b;

    assign w_in_fire   = in_valid & r_in_ready;
    assign w_out_fire  = r_out_valid & out_ready;
    assign w_fill_done = w_in_fire & (r_wr_cnt == LAST_WR);

    // Write pointer: next free slot of the bank being filled, wraps after N-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt <= '0;
        end else if (w_in_fire) begin
            r_wr_cnt <= w_fill_done ? '0 : r_wr_cnt + AW'(1);
        end
    end

    // Decide which pair to load into the output register next. Pair 0 of a
    // block that completes this very cycle takes x[N-1] straight from in_data,
    // because that sample only lands in the bank at this edge.
    always_comb begin
        w_nk     = '0;
        w_load   = 1'b0;
        w_bypass = 1'b0;
        if (w_out_fire && !r_out_last) begin
            w_load = 1'b1;
            w_nk   = r_rd_cnt + AW'(1);
        end else if (w_out_fire) begin
            if (w_other_full) begin
                w_load = 1'b1;
            end else if (w_fill_done && (w_wr_bank != w_rd_bank)) begin
                w_load   = 1'b1;
                w_bypass = 1'b1;
            end
        end else if (!r_out_valid && w_fill_done) begin
            w_load   = 1'b1;
            w_bypass = 1'b1;
        end
    end

`ifdef BFLY_FEEDER_PINGPONG_EN
    logic [1:0]          r_full;
    logic                r_wr_bank;
    logic                r_rd_bank;
    logic                w_sel;
    logic [1:0]          w_full_nxt;
    logic                w_wr_bank_nxt;
    logic signed [W-1:0] w_a0;
    logic signed [W-1:0] w_b0;
    logic signed [W-1:0] w_a1;
    logic signed [W-1:0] w_b1;

    assign w_wr_bank    = r_wr_bank;
    assign w_rd_bank    = r_rd_bank;
    assign w_other_full = r_full[~r_rd_bank];
    // After the last pair of a bank the next pair comes from the other bank.
    assign w_sel        = (w_out_fire && r_out_last) ? ~r_rd_bank : r_rd_bank;

    bfly_bank #(.W(W), .N(N)) u_bank0 (
        .clk     (clk),
        .i_we    (w_in_fire & (r_wr_bank == 1'b0)),
        .i_waddr (r_wr_cnt),
        .i_wdata (in_data),
        .i_rk    (w_nk),
        .o_rd_a  (w_a0),
        .o_rd_b  (w_b0)
    );

    bfly_bank #(.W(W), .N(N)) u_bank1 (
        .clk     (clk),
        .i_we    (w_in_fire & (r_wr_bank == 1'b1)),
        .i_waddr (r_wr_cnt),
        .i_wdata (in_data),
        .i_rk    (w_nk),
        .o_rd_a  (w_a1),
        .o_rd_b  (w_b1)
    );

    assign w_rd_a = w_sel ? w_a1 : w_a0;
    assign w_rd_b = w_sel ? w_b1 : w_b0;

    // Full flags: set when a bank completes, cleared when its last pair goes out.
    always_comb begin
        w_full_nxt    = r_full;
        w_wr_bank_nxt = r_wr_bank ^ w_fill_done;
        if (w_fill_done) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_out_fire && r_out_last) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    // Bank bookkeeping and the registered input-side ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full     <= 2'b00;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            r_full     <= w_full_nxt;
            r_wr_bank  <= w_wr_bank_nxt;
            r_rd_bank  <= r_rd_bank ^ (w_out_fire & r_out_last);
            r_in_ready <= ~w_full_nxt[w_wr_bank_nxt];
        end
    end

    assign dbg_state = r_full;
`else
    bfly_state_e         r_state;
    logic signed [W-1:0] w_a0;
    logic signed [W-1:0] w_b0;

    assign w_wr_bank    = 1'b0;
    assign w_rd_bank    = 1'b0;
    assign w_other_full = 1'b0;

    bfly_bank #(.W(W), .N(N)) u_bank0 (
        .clk     (clk),
        .i_we    (w_in_fire),
        .i_waddr (r_wr_cnt),
        .i_wdata (in_data),
        .i_rk    (w_nk),
        .o_rd_a  (w_a0),
        .o_rd_b  (w_b0)
    );

    assign w_rd_a = w_a0;
    assign w_rd_b = w_b0;

    // FILL accepts samples until the block is complete; DRAIN blocks input
    // until the last pair has been consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FILL;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_fill_done) begin
                        r_state    <= DRAIN;
                        r_in_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (w_out_fire && r_out_last) begin
                        r_state    <= FILL;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= FILL;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign dbg_state = {1'b0, r_state};
`endif

    // Output pair register: loads the next pair, clears when the stream runs
    // dry, and otherwise holds (which keeps a stalled pair stable).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_rd_cnt    <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_a     <= w_rd_a;
            r_out_b     <= w_bypass ? in_data : w_rd_b;
            r_out_idx   <= w_nk[KW-1:0];
            r_out_last  <= (w_nk == LAST_RD);
            r_rd_cnt    <= w_nk;
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_rd_cnt    <= '0;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;

endmodule
